// File: rtl/hdmi_link_pkg.sv
// Shared types and SCDC constants for the HDMI source link bring-up controller.
package hdmi_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    CONFIG,
    SCDC_VERSION,
    TMDS,
    RUN,
    FAIL
  } link_state_t;

  localparam logic [7:0] SOURCE_VERSION       = 8'h02;
  localparam logic [7:0] TMDS_CONFIG          = 8'h20;
  localparam logic [7:0] SCRAMBLER_STATUS     = 8'h21;
  localparam logic [7:0] SOURCE_VERSION_VALUE = 8'h01;

  typedef struct packed {
    logic [7:0] offset;
    logic [7:0] data;
  } table_entry_t;

  function automatic table_entry_t table_entry(input logic [255:0] tbl, input logic [3:0] index);
    return tbl[{index, 4'b0000} +: 16];
  endfunction

endpackage

// File: rtl/hdmi_link_timer.sv
// Loadable 32-bit down-counter with a zero flag; shared by HPD debounce and SCDC polling.
module hdmi_link_timer (
  input  logic        clock,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_value,
  output logic        zero
);

  logic [31:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 32'd1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/hdmi_link_manager.sv
// HDMI source link bring-up: HPD debounce, retimer table load, SCDC negotiation, retry/fail.
// Optional scrambler status polling in RUN is enabled by defining HDMI_SCDC_POLL_EN.
module hdmi_link_manager
  import hdmi_link_pkg::*;
#(
  parameter int unsigned  CLOCK_FREQUENCY  = 100_000_000,
  parameter int unsigned  HPD_DEBOUNCE_MS  = 100,
  parameter logic [6:0]   RETIMER_ADDRESS  = 7'h5E,
  parameter logic [6:0]   SCDC_ADDRESS     = 7'h54,
  parameter int unsigned  CONFIG_COUNT     = 9,
  parameter logic [255:0] CONFIG_TABLE     = 256'h0,
  parameter int unsigned  MAX_RETRIES      = 3,
  parameter int unsigned  POLL_INTERVAL_MS = 100
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       hpd,
  input  logic       tmds_clock_over_340mhz,
  output logic       i2c_request,
  output logic [6:0] i2c_address,
  output logic       i2c_rw,
  output logic [7:0] i2c_register,
  output logic [7:0] i2c_write_data,
  input  logic       i2c_done,
  input  logic       i2c_nack,
  input  logic [7:0] i2c_read_data,
  output logic       scrambler_enable,
  output logic       tmds_bit_clock_ratio,
  output logic       scdc_present,
  output logic       run,
  output logic       error
);

  localparam logic [31:0] DEBOUNCE_LOAD = 32'(CLOCK_FREQUENCY / 1000 * HPD_DEBOUNCE_MS - 1);
  localparam logic [31:0] POLL_LOAD     = 32'(CLOCK_FREQUENCY / 1000 * POLL_INTERVAL_MS - 1);
  localparam logic [3:0]  LAST_INDEX    = 4'(CONFIG_COUNT - 1);
  localparam logic [3:0]  RETRY_LIMIT   = 4'(MAX_RETRIES);

  link_state_t  state;
  logic         hpd_meta;
  logic         hpd_s;
  logic [3:0]   config_index;
  logic [3:0]   retry_count;
  logic         done_valid;
  logic         retry_event;
  logic         timer_load;
  logic         poll_reload;
  logic [31:0]  timer_value;
  logic         timer_zero;
  table_entry_t first_entry;
  table_entry_t next_entry;
  logic         read_data_unused;

`ifdef HDMI_SCDC_POLL_EN
  logic         miss_pending;
`endif

  assign read_data_unused = ^i2c_read_data;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hpd_meta <= 1'b0;
      hpd_s    <= 1'b0;
    end else begin
      hpd_meta <= hpd;
      hpd_s    <= hpd_meta;
    end
  end

  assign done_valid  = i2c_done & i2c_request;
  assign first_entry = table_entry(CONFIG_TABLE, 4'd0);
  assign next_entry  = table_entry(CONFIG_TABLE, config_index + 4'd1);

  // An SCDC version NACK only counts as a failure when the mode needs scrambling.
  assign retry_event = hpd_s & done_valid & i2c_nack &
                       ((state == CONFIG) || (state == TMDS) ||
                        ((state == SCDC_VERSION) && tmds_bit_clock_ratio));

  always_comb begin
    timer_load  = 1'b0;
    poll_reload = 1'b0;
    if (state == IDLE) begin
      timer_load = hpd_s;
    end
    if (retry_event) begin
      timer_load = 1'b1;
    end
`ifdef HDMI_SCDC_POLL_EN
    if (((state == TMDS) && done_valid && !i2c_nack) || ((state == RUN) && done_valid)) begin
      timer_load  = 1'b1;
      poll_reload = 1'b1;
    end
`endif
  end

  assign timer_value = poll_reload ? POLL_LOAD : DEBOUNCE_LOAD;

  hdmi_link_timer u_timer (
    .clock      (clock),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      config_index         <= '0;
      retry_count          <= '0;
      i2c_request          <= 1'b0;
      i2c_address          <= '0;
      i2c_rw               <= 1'b0;
      i2c_register         <= '0;
      i2c_write_data       <= '0;
      scrambler_enable     <= 1'b0;
      tmds_bit_clock_ratio <= 1'b0;
      scdc_present         <= 1'b0;
      run                  <= 1'b0;
      error                <= 1'b0;
`ifdef HDMI_SCDC_POLL_EN
      miss_pending         <= 1'b0;
`endif
    end else begin
      if (state == IDLE) begin
        scrambler_enable     <= tmds_clock_over_340mhz;
        tmds_bit_clock_ratio <= tmds_clock_over_340mhz;
      end

      if (!hpd_s) begin
        state        <= IDLE;
        i2c_request  <= 1'b0;
        i2c_rw       <= 1'b0;
        run          <= 1'b0;
        scdc_present <= 1'b0;
        error        <= 1'b0;
      end else if (retry_event) begin
        i2c_request <= 1'b0;
        if (retry_count == RETRY_LIMIT) begin
          state <= FAIL;
          error <= 1'b1;
        end else begin
          retry_count <= retry_count + 4'd1;
          state       <= WAIT;
        end
      end else begin
        case (state)
          IDLE: begin
            retry_count <= '0;
`ifdef HDMI_SCDC_POLL_EN
            miss_pending <= 1'b0;
`endif
            state <= WAIT;
          end
          WAIT: begin
            if (timer_zero) begin
              i2c_request    <= 1'b1;
              i2c_address    <= RETIMER_ADDRESS;
              i2c_rw         <= 1'b0;
              i2c_register   <= first_entry.offset;
              i2c_write_data <= first_entry.data;
              config_index   <= '0;
              state          <= CONFIG;
            end
          end
          CONFIG: begin
            if (done_valid) begin
              if (config_index == LAST_INDEX) begin
                i2c_address    <= SCDC_ADDRESS;
                i2c_register   <= SOURCE_VERSION;
                i2c_write_data <= SOURCE_VERSION_VALUE;
                state          <= SCDC_VERSION;
              end else begin
                config_index   <= config_index + 4'd1;
                i2c_register   <= next_entry.offset;
                i2c_write_data <= next_entry.data;
              end
            end
          end
          SCDC_VERSION: begin
            if (done_valid) begin
              if (i2c_nack) begin
                i2c_request  <= 1'b0;
                scdc_present <= 1'b0;
                run          <= 1'b1;
                state        <= RUN;
              end else begin
                scdc_present   <= 1'b1;
                i2c_register   <= TMDS_CONFIG;
                i2c_write_data <= {6'b0, tmds_bit_clock_ratio, scrambler_enable};
                state          <= TMDS;
              end
            end
          end
          TMDS: begin
            if (done_valid) begin
              i2c_request <= 1'b0;
              run         <= 1'b1;
              state       <= RUN;
            end
          end
          RUN: begin
            run <= 1'b1;
`ifdef HDMI_SCDC_POLL_EN
            if (!i2c_request) begin
              if (timer_zero && scdc_present && tmds_bit_clock_ratio) begin
                i2c_request    <= 1'b1;
                i2c_rw         <= 1'b1;
                i2c_address    <= SCDC_ADDRESS;
                i2c_register   <= SCRAMBLER_STATUS;
                i2c_write_data <= '0;
              end
            end else if (done_valid) begin
              i2c_request <= 1'b0;
              i2c_rw      <= 1'b0;
              if (!i2c_nack && i2c_read_data[0]) begin
                miss_pending <= 1'b0;
              end else if (miss_pending) begin
                // Second consecutive miss: drop the link and rewrite TMDS config.
                miss_pending   <= 1'b0;
                run            <= 1'b0;
                i2c_request    <= 1'b1;
                i2c_register   <= TMDS_CONFIG;
                i2c_write_data <= {6'b0, tmds_bit_clock_ratio, scrambler_enable};
                state          <= TMDS;
              end else begin
                miss_pending <= 1'b1;
              end
            end
`endif
          end
          FAIL: begin
            error       <= 1'b1;
            i2c_request <= 1'b0;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
